sram_stream_adapter: RTL
========================

# sram_stream_adapter

Valid/ready front-end for the single-port instance of the technology SRAM wrapper. Sits directly upstream of the SRAM: it converts a request stream (read/write with byte enables) into the SRAM's fixed-latency req/we/addr/wdata/be interface. It captures read data after the configured latency into a credit-protected response FIFO, so back-pressure on the response side never drops data.

## Interface
- NumWords, 1024, SRAM depth in words.
- DataWidth, 128, data width in bits.
- ByteWidth, 8, bits per byte-enable lane.
- Latency, 1, SRAM read latency in cycles; must be ≥1 and match the SRAM instance.
- FifoDepth, Latency+2, response FIFO entries; must be ≥Latency+1. Latency+2 gives full throughput.
- AddrWidth, (NumWords>1 ? $clog2(NumWords) : 1), derived.
- BeWidth, ceil(DataWidth/ByteWidth), derived.
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  AddrWidth  word address.
- req_wdata_i  in  DataWidth  write data.
- req_be_i  in  BeWidth  byte enables (writes only).
- rsp_valid_o  out  1  read response valid.
- rsp_ready_i  in  1  read response ready.
- rsp_rdata_o  out  DataWidth  read data.
- sram_req_o  out  1  SRAM request.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  AddrWidth  SRAM address.
- sram_wdata_o  out  DataWidth  SRAM write data.
- sram_be_o  out  BeWidth  SRAM byte enables.
- sram_rdata_i  in  DataWidth  SRAM read data, valid Latency cycles after a read request.

## Operation
- Credit counter `cnt` (width $clog2(FifoDepth+1)) = reads in flight + FIFO occupancy.
  - +1 on an accepted read.
  - −1 on a response handshake (rsp_valid_o & rsp_ready_i).
  - Both in the same cycle: unchanged.
- req_ready_o = (cnt < FifoDepth). It is registered-state only: no combinational path from rsp_ready_i or from the request payload. Writes are gated by the same credit check.
- Accept = req_valid_i & req_ready_o.
- The SRAM side is pass-through:
  - sram_req_o = accept.
  - sram_we_o = req_we_i & accept.
  - addr, wdata and be are forwarded unmodified.
- Writes produce no response.
- Read tag pipeline: a Latency-stage shift register carries a bit set on each accepted read. When the bit emerges, sram_rdata_i is pushed into the FIFO. The push can never overflow, because credits guarantee space.
- FIFO: circular buffer with read/write pointers wrapping at FifoDepth.
  - rsp_valid_o = FIFO not empty.
  - rsp_rdata_o = head entry.
  - Responses are delivered in request order.
- Simultaneous push and pop on a FIFO holding one entry: the head pops and the new entry becomes head next cycle. Occupancy is unchanged.
- Reset (async, any time):
  - cnt = 0; tag pipeline and FIFO pointers cleared.
  - In-flight reads are discarded.
  - Output values under reset: req_ready_o = 1, rsp_valid_o = 0, rsp_rdata_o = 0, sram_req_o = req_valid_i. Drive req_valid_i low during reset.

## Timing
- A read accepted in cycle 0 is pushed into the FIFO at the end of cycle Latency. rsp_valid_o rises in cycle Latency+1, giving request-to-response latency Latency+1.
- A write accepted in cycle 0 reaches the SRAM in cycle 0.
- With FifoDepth = Latency+2 and rsp_ready_i held high, one read per cycle is sustained indefinitely.
- With FifoDepth = Latency+1, throughput is at most (Latency+1) reads per (Latency+2) cycles.
- With rsp_ready_i low, req_ready_o falls once cnt reaches FifoDepth. It rises again the cycle after the first pop.

## Configuration
- SRAM_STREAM_ADAPTER_BYPASS_EN:
  - Defined: when the FIFO is empty and a read emerges from the tag pipeline, sram_rdata_i is presented combinationally on rsp_rdata_o with rsp_valid_o = 1 in cycle Latency. If rsp_ready_i = 1 in that cycle, the data is not stored and cnt decrements. Otherwise it is pushed as normal. Read latency becomes Latency.
  - Undefined: every read passes through the FIFO; latency is Latency+1.

## Test plan
- Reset, then write 0xA5..A5 to address 3 with be = all-ones, then read address 3 (Latency=1) → rsp_valid_o in cycle 2 after read accept, rsp_rdata_o = 0xA5..A5.
- Partial write: write 0xFF..FF, then write 0x00..00 with be = 0x0001, then read → byte 0 = 0x00, all other bytes = 0xFF.
- 16 back-to-back reads of addresses 0..15 with rsp_ready_i = 1 and FifoDepth = Latency+2 → req_ready_o never drops; responses arrive in order, one per cycle.
- Hold rsp_ready_i = 0 and issue reads → exactly FifoDepth accepted before req_ready_o = 0. Release → all FifoDepth responses delivered in order; req_ready_o returns the cycle after the first pop.
- Assert rst_ni low with 2 reads in flight and 1 in the FIFO → rsp_valid_o = 0 and req_ready_o = 1 immediately. No stale responses after release.
- With SRAM_STREAM_ADAPTER_BYPASS_EN defined, empty FIFO and rsp_ready_i = 1 → a read accepted in cycle 0 is returned in cycle Latency.

Source files
------------

// File: rtl/sram_stream_adapter.sv
// Valid/ready request stream to fixed-latency single-port SRAM, with credit-protected read response FIFO.
// Optional macro SRAM_STREAM_ADAPTER_BYPASS_EN: return read data combinationally when the FIFO is empty.
module sram_stream_adapter #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  parameter int unsigned FifoDepth = Latency + 2,
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam int unsigned CntW = $clog2(FifoDepth + 1);
  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  logic [CntW-1:0]      cnt;
  logic [CntW-1:0]      occ;
  logic [Latency-1:0]   tag;
  logic [PtrW-1:0]      wptr;
  logic [PtrW-1:0]      rptr;
  logic [DataWidth-1:0] mem [FifoDepth];

  logic accept;
  logic rd_accept;
  logic tag_out;
  logic empty;
  logic bypass;
  logic push;
  logic pop;
  logic rsp_hs;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Credits cover reads in flight plus stored responses, so ready depends on state only.
  assign req_ready_o = (cnt < CntW'(FifoDepth));
  assign accept      = req_valid_i & req_ready_o;
  assign rd_accept   = accept & ~req_we_i;

  assign sram_req_o   = accept;
  assign sram_we_o    = req_we_i & accept;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_be_i;

  assign tag_out = tag[Latency-1];
  assign empty   = (occ == '0);

`ifdef SRAM_STREAM_ADAPTER_BYPASS_EN
  // Emerging read data skips the FIFO when nothing older is queued and the consumer takes it now.
  assign bypass      = tag_out & empty & rsp_ready_i;
  assign rsp_valid_o = ~empty | tag_out;
  assign rsp_rdata_o = ~empty ? mem[rptr] : (tag_out ? sram_rdata_i : '0);
`else
  assign bypass      = 1'b0;
  assign rsp_valid_o = ~empty;
  assign rsp_rdata_o = empty ? '0 : mem[rptr];
`endif

  assign push   = tag_out & ~bypass;
  assign pop    = ~empty & rsp_ready_i;
  assign rsp_hs = rsp_valid_o & rsp_ready_i;

  // Credit counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else begin
      case ({rd_accept, rsp_hs})
        2'b10:   cnt <= cnt + CntW'(1);
        2'b01:   cnt <= cnt - CntW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Read tag pipeline, one stage per cycle of SRAM latency
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag <= '0;
    end else begin
      tag <= Latency'({tag, rd_accept});
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   occ <= occ + CntW'(1);
        2'b01:   occ <= occ - CntW'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= sram_rdata_i;
  end

endmodule
